// File: rtl/hazard_ctrl.sv
// Pipeline hazard/halt controller: load-use stall, branch squash, halt drain.
// Ports: clk, rst (async active-low), IF/ID source fields, ID/EX load/dst,
//   ex_branch_taken in; pc_wen, ifid_wen, ifid_flush, idex_bubble, halted out.
// Optional HAZ_PERF_CNT_EN: adds CNT_W parameter and the saturating
//   stall_cycles / flush_count counter ports.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] IFIDrs,
    input  logic [3:0] IFIDrt,
    input  logic       IFIDuse_rs,
    input  logic       IFIDuse_rt,
    input  logic       IFIDHLT,
    input  logic       IDEXMemRead,
    input  logic [3:0] IDEXdst,
    input  logic       ex_branch_taken,
    output logic       pc_wen,
    output logic       ifid_wen,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       halted
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [3:0] DCNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic       lu;

    // R0 is hardwired zero, so a load to R0 never creates a hazard.
    assign lu = IDEXMemRead && (IDEXdst != 4'd0) &&
                ((IFIDuse_rs && (IFIDrs == IDEXdst)) ||
                 (IFIDuse_rt && (IFIDrt == IDEXdst)));

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (ex_branch_taken) begin
                    // Squashes any load-use or HLT seen this cycle.
                    pc_wen     = 1'b1;
                    ifid_wen   = 1'b1;
                    ifid_flush = 1'b1;
                end else if (lu) begin
                    idex_bubble = 1'b1;
                end else if (IFIDHLT) begin
                    // HLT moves into ID/EX; fetch stops behind it.
                    ifid_wen    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b0;
                    state_d     = S_DRAIN;
                    dcnt_d      = DCNT_INIT;
                end else begin
                    pc_wen      = 1'b1;
                    ifid_wen    = 1'b1;
                    idex_bubble = 1'b0;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == 4'd0) begin
                    state_d = S_HALTED;
                end else begin
                    dcnt_d = dcnt_q - 4'd1;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
        // Hold the pipeline quiescent while reset is asserted.
        if (!rst) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            dcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             run;

    assign run = (state_q == S_RUN);

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (run && lu && !ex_branch_taken && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (run && ex_branch_taken && (flush_q != '1)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stall, R0, branch priority, halt drain,
// asynchronous reset, and (with HAZ_PERF_CNT_EN) counter saturation.
module tb_hazard_ctrl;

    // {pc_wen, ifid_wen, ifid_flush, idex_bubble, halted}
    localparam logic [4:0] E_RUN = 5'b11000;
    localparam logic [4:0] E_STL = 5'b00010;
    localparam logic [4:0] E_BR  = 5'b11110;
    localparam logic [4:0] E_HLT = 5'b01100;
    localparam logic [4:0] E_DRN = 5'b00010;
    localparam logic [4:0] E_HLD = 5'b00011;
    localparam logic [4:0] E_RST = 5'b00010;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] IFIDrs, IFIDrt, IDEXdst;
    logic       IFIDuse_rs, IFIDuse_rt, IFIDHLT;
    logic       IDEXMemRead, ex_branch_taken;
    logic       pc_wen, ifid_wen, ifid_flush, idex_bubble, halted;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

`ifdef HAZ_PERF_CNT_EN
    logic [3:0] stall_cycles, flush_count;
    logic [3:0] exp_stall = 4'd0;
    logic [3:0] exp_flush = 4'd0;

    hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut (
`else
    hazard_ctrl #(.DRAIN_CYCLES(4)) dut (
`endif
        .clk(clk), .rst(rst),
        .IFIDrs(IFIDrs), .IFIDrt(IFIDrt),
        .IFIDuse_rs(IFIDuse_rs), .IFIDuse_rt(IFIDuse_rt),
        .IFIDHLT(IFIDHLT), .IDEXMemRead(IDEXMemRead),
        .IDEXdst(IDEXdst), .ex_branch_taken(ex_branch_taken),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .halted(halted)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] obs();
        return {pc_wen, ifid_wen, ifid_flush, idex_bubble, halted};
    endfunction

    task automatic pop_check();
        sb_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard empty");
            return;
        end
        e = sb.pop_front();
        n_vec++;
        assert (obs() === e.exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs(), e.exp);
        end
    endtask

    task automatic push(input string tag, input logic [4:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] rs, input logic [3:0] rt,
                         input logic urs, input logic urt,
                         input logic hlt, input logic mr,
                         input logic [3:0] dst, input logic br);
        IFIDrs          = rs;
        IFIDrt          = rt;
        IFIDuse_rs      = urs;
        IFIDuse_rt      = urt;
        IFIDHLT         = hlt;
        IDEXMemRead     = mr;
        IDEXdst         = dst;
        ex_branch_taken = br;
    endtask

    // kind: 0 none, 1 counted stall, 2 counted flush
    task automatic step(input string tag, input logic [4:0] exp,
                        input int kind);
        push(tag, exp);
        @(negedge clk);
        pop_check();
`ifdef HAZ_PERF_CNT_EN
        n_vec++;
        assert (stall_cycles === exp_stall) else begin
            n_err++;
            $error("FAIL %s stall_cycles: observed %0d expected %0d",
                   tag, stall_cycles, exp_stall);
        end
        n_vec++;
        assert (flush_count === exp_flush) else begin
            n_err++;
            $error("FAIL %s flush_count: observed %0d expected %0d",
                   tag, flush_count, exp_flush);
        end
        if (kind == 1 && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
        if (kind == 2 && exp_flush != 4'hF) exp_flush = exp_flush + 4'd1;
`else
        if (kind < 0) $display("unused kind");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_drive();
        drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        push(tag, E_RST);
        pop_check();
`ifdef HAZ_PERF_CNT_EN
        exp_stall = 4'd0;
        exp_flush = 4'd0;
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        #1;
        push("reset_outputs", E_RST);
        pop_check();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        drive(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        step("run_fetch", E_RUN, 0);

        drive(4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        step("lu_rs", E_STL, 1);
        drive(4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
        step("lu_release", E_RUN, 0);

        drive(4'd1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
        step("lu_rt", E_STL, 1);

        drive(4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        step("r0_no_hazard", E_RUN, 0);
        drive(4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        step("unused_rt", E_RUN, 0);

        drive(4'd6, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1);
        step("branch_prio", E_BR, 2);
        drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step("after_branch", E_RUN, 0);

        drive(4'd9, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
        step("hlt_with_lu", E_STL, 1);
        drive(4'd9, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
        step("hlt_accept", E_HLT, 0);
        for (int i = 0; i < 4; i++) begin
            rnd_drive();
            step("drain", E_DRN, 0);
        end
        for (int i = 0; i < 20; i++) begin
            rnd_drive();
            step("halted_sticky", E_HLD, 0);
        end

        async_reset("reset_from_halted");
        drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step("run_after_halt", E_RUN, 0);

        drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step("hlt2_accept", E_HLT, 0);
        drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step("drain2", E_DRN, 0);
        async_reset("reset_mid_drain");
        drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step("run_after_drain_rst", E_RUN, 0);

        for (int i = 0; i < 20; i++) begin
            drive(4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
            step("sat_stall", E_STL, 1);
        end
        drive(4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0);
        step("after_sat", E_RUN, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and halt controller. It consumes the ID/EX register outputs together with the IF/ID source fields, and drives the write enables, flush and bubble controls for the PC, IF/ID and ID/EX registers.
- Handles load-use stalls, taken-branch squashes, and a halt-drain sequence that stops fetch and lets older instructions retire before asserting halted.

Parameters:
- DRAIN_CYCLES, 4: cycles after HLT enters ID/EX before halted asserts; covers the EX, MEM and WB drain plus one margin cycle. Legal range 1..15.
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- IFIDrs, input, 4: source register rs of the instruction in ID.
- IFIDrt, input, 4: source register rt of the instruction in ID.
- IFIDuse_rs, input, 1: the ID instruction reads rs.
- IFIDuse_rt, input, 1: the ID instruction reads rt.
- IFIDHLT, input, 1: the ID instruction is HLT.
- IDEXMemRead, input, 1: the EX instruction is a load.
- IDEXdst, input, 4: destination register of the EX instruction, already muxed.
- ex_branch_taken, input, 1: the branch in EX resolved taken this cycle.
- pc_wen, output, 1: PC register write enable.
- ifid_wen, output, 1: IF/ID register write enable.
- ifid_flush, output, 1: load a NOP into IF/ID at the next edge.
- idex_bubble, output, 1: zero all ID/EX control bits at the next edge.
- halted, output, 1: the processor is halted.
- stall_cycles, output, CNT_W: present only when HAZ_PERF_CNT_EN is defined.
- flush_count, output, CNT_W: present only when HAZ_PERF_CNT_EN is defined.

Behaviour:
- State register with states RUN, DRAIN and HALTED, plus a 4-bit drain counter dcnt.
- Asynchronous reset (rst=0): state=RUN, dcnt=0, counters=0.
- Outputs while rst=0 are forced to pc_wen=0, ifid_wen=0, ifid_flush=0, idex_bubble=1, halted=0.
- Outputs are combinational from the state and the current inputs, giving zero-latency control for the upcoming edge.
- Load-use condition lu: IDEXMemRead && IDEXdst!=0 && ((IFIDuse_rs && IFIDrs==IDEXdst) || (IFIDuse_rt && IFIDrt==IDEXdst)).
  - R0 is hardwired zero and never causes a hazard.
- RUN, priority order:
  1. ex_branch_taken: pc_wen=1, ifid_wen=1, ifid_flush=1, idex_bubble=1. Stay in RUN. This squashes any lu or IFIDHLT seen in the same cycle.
  2. lu: pc_wen=0, ifid_wen=0, ifid_flush=0, idex_bubble=1. Stay in RUN.
     - Exactly one stall cycle results, because the bubble clears IDEXMemRead.
     - Back-to-back loads re-evaluate lu on every cycle.
  3. IFIDHLT: pc_wen=0, ifid_wen=1, ifid_flush=1, idex_bubble=0, so HLT advances into ID/EX. Next state DRAIN with dcnt=DRAIN_CYCLES-1.
  4. Otherwise: pc_wen=1, ifid_wen=1, ifid_flush=0, idex_bubble=0.
- An IFIDHLT that coincides with lu stalls first. The HLT is then accepted on the following cycle.
- DRAIN:
  - Outputs: pc_wen=0, ifid_wen=0, ifid_flush=0, idex_bubble=1, halted=0.
  - ex_branch_taken, lu and IFIDHLT are ignored; no instruction older than HLT can resolve a branch.
  - dcnt decrements each cycle. When dcnt==0 the next state is HALTED.
  - DRAIN_CYCLES=1 gives HALTED one cycle after entry.
- HALTED:
  - Outputs: pc_wen=0, ifid_wen=0, ifid_flush=0, idex_bubble=1, halted=1.
  - The state is sticky until rst.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately and asynchronously. The drain sequence is discarded.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each RUN cycle where lu stalls, i.e. lu with no branch.
  - flush_count increments on each RUN cycle with ex_branch_taken.
  - Both counters saturate at all-ones. Both are frozen in DRAIN and HALTED. Both reset to 0.
- Undefined: both ports and both counters are absent; the control behaviour is identical.

Test Plan:
- Load-use: IDEXMemRead=1, IDEXdst=5, IFIDrs=5, IFIDuse_rs=1 -> pc_wen=0, ifid_wen=0, idex_bubble=1 for one cycle. Next cycle IDEXMemRead=0 -> pc_wen=1.
- R0 and unused source: IDEXdst=0 with IFIDrs=0, then IDEXdst=3 with IFIDrt=3 and IFIDuse_rt=0 -> no stall (pc_wen=1).
- Branch priority: ex_branch_taken=1 together with lu=1 and IFIDHLT=1 -> ifid_flush=1, idex_bubble=1, pc_wen=1, state stays RUN. With the perf macro, flush_count=1 and stall_cycles=0.
- Halt: IFIDHLT=1 at cycle t -> ifid_wen=1, ifid_flush=1, pc_wen=0 at t. DRAIN covers t+1..t+4. halted=1 from t+5 and stays 1 for 20 more cycles with random inputs.
- Reset mid-drain: drive rst=0 at t+2 asynchronously between edges -> halted=0 and idex_bubble=1 immediately. After rst=1, normal RUN fetch gives pc_wen=1.
- Saturation: with CNT_W=4 and the perf macro, 20 consecutive load-use stalls -> stall_cycles=15.
